// File: rtl/fc_param_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fc_param_loader
//  Description : Streams the bias words and then the weight words of one FC
//                layer from an external synchronous ROM, one beat at a time,
//                over a strobe/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_param_loader #(
    parameter int DW     = 32,
    parameter int in_ch  = 16,
    parameter int in_seq = 1,
    parameter int out_ch = 5,
    parameter int AW     = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  i_start,
    input  logic [AW-1:0]         i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rom_en,
    output logic [AW-1:0]         o_rom_addr,
    input  logic [DW*in_ch-1:0]   i_rom_data,
    output logic                  o_EN_w,
    output logic [DW*in_ch-1:0]   o_data,
    output logic                  o_stb_out,
    input  logic                  i_ack_in
);

    // Beat budget: bias words first, then in_seq weight words per channel.
    localparam int BIAS_RAW   = (out_ch + in_ch - 1) / in_ch;
    localparam int BIAS_BEATS = (BIAS_RAW < 1) ? 1 : BIAS_RAW;
    localparam int WGT_BEATS  = in_seq * out_ch;
    localparam int TOTAL      = BIAS_BEATS + WGT_BEATS;
    localparam int CW         = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(TOTAL - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [AW-1:0]       base_q,  base_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic                stb_q,   stb_d;
    logic [DW*in_ch-1:0] data_q,  data_d;
    logic [AW-1:0]       w_rom_addr;

    // Address wraps naturally at 2^AW.
    assign w_rom_addr = base_q + AW'(cnt_q);

    // State, base address, beat counter and the outgoing beat register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: one ROM read, one capture and one handshake per beat.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_START;
                    base_d  = i_base_addr;
                    cnt_d   = '0;
                end
            end
            S_START: state_d = S_FETCH;
            S_FETCH: state_d = S_CAPT;
            S_CAPT: begin
                // ROM word is valid now, one cycle after the read strobe.
                data_d  = i_rom_data;
                stb_d   = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (stb_q && i_ack_in) begin
                    stb_d = 1'b0;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_EN_w     = (state_q == S_START);
    assign o_rom_en   = (state_q == S_FETCH);
    assign o_rom_addr = (state_q == S_FETCH) ? w_rom_addr : '0;
    assign o_stb_out  = stb_q;
    assign o_data     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_param_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_param_loader
//  Description : Directed self-checking bench for fc_param_loader with a
//                synchronous ROM model and an FC-layer receive model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_param_loader;

    localparam int W = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // ---------------- DUT A: default parameters ----------------
    logic          rst_a, start_a, ack_a;
    logic [7:0]    base_a, rom_addr_a;
    logic          busy_a, done_a, rom_en_a, en_w_a, stb_a;
    logic [W-1:0]  rom_data_a, data_a;

    fc_param_loader dut_a (
        .clk(clk), .RST(rst_a), .i_start(start_a), .i_base_addr(base_a),
        .o_busy(busy_a), .o_done(done_a), .o_rom_en(rom_en_a),
        .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a), .o_EN_w(en_w_a),
        .o_data(data_a), .o_stb_out(stb_a), .i_ack_in(ack_a)
    );

    // ---------------- DUT B: 20 channels, 2 beats per channel ----------------
    logic          rst_b, start_b, ack_b;
    logic [7:0]    base_b, rom_addr_b;
    logic          busy_b, done_b, rom_en_b, en_w_b, stb_b;
    logic [W-1:0]  rom_data_b, data_b;

    fc_param_loader #(.out_ch(20), .in_seq(2)) dut_b (
        .clk(clk), .RST(rst_b), .i_start(start_b), .i_base_addr(base_b),
        .o_busy(busy_b), .o_done(done_b), .o_rom_en(rom_en_b),
        .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b), .o_EN_w(en_w_b),
        .o_data(data_b), .o_stb_out(stb_b), .i_ack_in(ack_b)
    );

    // ROM image: every lane encodes its address and lane number.
    function automatic logic [W-1:0] rom_word(input logic [7:0] a);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < 16; k++)
            w[k*32 +: 32] = {a ^ 8'hC3, 8'(k), ~a, 8'(k * 7 + 1)};
        return w;
    endfunction

    // Synchronous ROMs: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= rom_word(rom_addr_a);
        if (rom_en_b) rom_data_b <= rom_word(rom_addr_b);
    end

    // ---------------- monitors / FC-layer receive models ----------------
    int           cyc = 0;
    int           en_cnt_a, xfer_cnt_a, done_cnt_a, done_cyc_a, viol_a, hold_viol_a;
    logic [7:0]   addr_log_a[$];
    logic [W-1:0] data_log_a[$];
    int           xfer_cyc_a[$];
    logic         prev_wait_a = 1'b0;
    logic [W-1:0] prev_data_a;

    always @(negedge clk) begin
        cyc++;
        if (en_w_a) en_cnt_a++;
        if (en_w_a && stb_a) viol_a++;
        if (rom_en_a) addr_log_a.push_back(rom_addr_a);
        if (stb_a && ack_a) begin
            xfer_cnt_a++;
            data_log_a.push_back(data_a);
            xfer_cyc_a.push_back(cyc);
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (prev_wait_a && (!stb_a || data_a !== prev_data_a || rom_en_a))
            hold_viol_a++;
        prev_wait_a = stb_a && !ack_a;
        prev_data_a = data_a;
    end

    int           en_cnt_b = 0, xfer_cnt_b = 0, done_cnt_b = 0, viol_b = 0;
    logic [7:0]   addr_log_b[$];
    logic [W-1:0] data_log_b[$];

    always @(negedge clk) begin
        if (en_w_b) en_cnt_b++;
        if (en_w_b && stb_b) viol_b++;
        if (rom_en_b) addr_log_b.push_back(rom_addr_b);
        if (stb_b && ack_b) begin
            xfer_cnt_b++;
            data_log_b.push_back(data_b);
        end
        if (done_b) done_cnt_b++;
    end

    // ---------------- helpers ----------------
    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_a();
        addr_log_a.delete();
        data_log_a.delete();
        xfer_cyc_a.delete();
        en_cnt_a = 0; xfer_cnt_a = 0; done_cnt_a = 0; done_cyc_a = 0;
        viol_a = 0; hold_viol_a = 0;
    endtask

    task automatic wait_done_a(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done_cnt_a != 0) break;
            tick();
        end
        chk_int({tag, "_done_seen"}, done_cnt_a, 1);
    endtask

    // Address order and FC scoreboard: 1 bias beat then 5 weight beats.
    task automatic check_run_a(input string tag, input logic [7:0] base);
        chk_int({tag, "_xfers"}, xfer_cnt_a, 6);
        chk_int({tag, "_reads"}, addr_log_a.size(), 6);
        for (int i = 0; i < addr_log_a.size(); i++)
            chk_int($sformatf("%s_addr%0d", tag, i), int'(addr_log_a[i]), int'(8'(base + 8'(i))));
        for (int i = 0; i < data_log_a.size(); i++)
            chk_vec($sformatf("%s_%s%0d", tag, (i < 1) ? "bias" : "wgt", (i < 1) ? i : i - 1),
                    data_log_a[i], rom_word(8'(base + 8'(i))));
        chk_int({tag, "_stb_enw_overlap"}, viol_a, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        base_a = '0; base_b = '0;
        ack_a = 1'b0; ack_b = 1'b0;
        clear_a();
        #1;
        chk_int("rst_busy",  busy_a, 0);
        chk_int("rst_done",  done_a, 0);
        chk_int("rst_romen", rom_en_a, 0);
        chk_int("rst_enw",   en_w_a, 0);
        chk_int("rst_stb",   stb_a, 0);
        chk_int("rst_addr",  int'(rom_addr_a), 0);
        chk_vec("rst_data",  data_a, '0);
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Run 1: base 0x10, ack held high.
        clear_a();
        base_a = 8'h10; ack_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a("t1", 60);
        chk_int("t1_enw_pulses", en_cnt_a, 1);
        check_run_a("t1", 8'h10);
        if (xfer_cyc_a.size() == 6) begin
            chk_int("t1_done_latency", done_cyc_a - xfer_cyc_a[5], 1);
            for (int i = 1; i < 6; i++)
                chk_int($sformatf("t1_period%0d", i), xfer_cyc_a[i] - xfer_cyc_a[i-1], 3);
        end
        tick();
        chk_int("t1_idle_busy", busy_a, 0);
        chk_int("t1_done_width", done_cnt_a, 1);

        // Run 2: ack withheld 4 cycles on beat 2.
        clear_a();
        base_a = 8'h40; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 30 && xfer_cnt_a < 1; i++) tick();
        ack_a = 1'b0;
        for (int i = 0; i < 10 && !stb_a; i++) tick();
        repeat (4) tick();
        chk_int("t2_still_waiting", stb_a, 1);
        ack_a = 1'b1;
        wait_done_a("t2", 60);
        check_run_a("t2", 8'h40);
        chk_int("t2_hold_stable", hold_viol_a, 0);
        if (xfer_cyc_a.size() == 6)
            chk_int("t2_stalled_gap", xfer_cyc_a[1] - xfer_cyc_a[0], 7);
        tick();

        // Run 3: start pulsed during beat 3 must be ignored.
        clear_a();
        base_a = 8'h80; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 30 && xfer_cnt_a < 2; i++) tick();
        base_a = 8'h55; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a("t3", 60);
        check_run_a("t3", 8'h80);
        repeat (3) tick();
        chk_int("t3_no_restart_busy", busy_a, 0);
        chk_int("t3_enw_pulses", en_cnt_a, 1);

        // Run 4: reset asserted in SEND of beat 4.
        clear_a();
        base_a = 8'h20; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 40 && !(xfer_cnt_a == 3 && stb_a); i++) tick();
        chk_int("t4_in_send_beat4", stb_a, 1);
        rst_a = 1'b1;
        #1;
        chk_int("t4_rst_busy",  busy_a, 0);
        chk_int("t4_rst_stb",   stb_a, 0);
        chk_int("t4_rst_romen", rom_en_a, 0);
        chk_int("t4_rst_enw",   en_w_a, 0);
        chk_int("t4_rst_done",  done_a, 0);
        chk_int("t4_rst_addr",  int'(rom_addr_a), 0);
        chk_vec("t4_rst_data",  data_a, '0);
        tick();
        rst_a = 1'b0;
        repeat (8) tick();
        chk_int("t4_aborted_xfers", xfer_cnt_a, 3);
        chk_int("t4_idle_after_rst", busy_a, 0);
        clear_a();
        base_a = 8'h30; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a("t4b", 60);
        check_run_a("t4b", 8'h30);

        // Run 5: 2 bias + 40 weight beats, address wraps past 0xFF.
        base_b = 8'hF0; ack_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 200 && done_cnt_b == 0; i++) tick();
        chk_int("t5_done_seen", done_cnt_b, 1);
        chk_int("t5_enw_pulses", en_cnt_b, 1);
        chk_int("t5_xfers", xfer_cnt_b, 42);
        chk_int("t5_reads", addr_log_b.size(), 42);
        for (int i = 0; i < addr_log_b.size(); i++)
            chk_int($sformatf("t5_addr%0d", i), int'(addr_log_b[i]), (8'hF0 + i) % 256);
        for (int i = 0; i < data_log_b.size(); i++)
            chk_vec($sformatf("t5_%s%0d", (i < 2) ? "bias" : "wgt", (i < 2) ? i : i - 2),
                    data_log_b[i], rom_word(8'((8'hF0 + i) % 256)));
        chk_int("t5_stb_enw_overlap", viol_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fc_param_loader.md
FC_PARAM_LOADER -- requirements
Module: fc_param_loader

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the width of one data lane.
REQ-002 The block SHALL have parameter in_ch, default 16, meaning the number of lanes per beat.
REQ-003 The block SHALL have parameter in_seq, default 1, meaning the weight beats per output channel.
REQ-004 The block SHALL have parameter out_ch, default 5, meaning the number of output channels of the fed FC layer.
REQ-005 The block SHALL have parameter AW, default 8, meaning the ROM address width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port i_start, input, 1 bit: load request; sampled only in IDLE.
REQ-009 The block SHALL have port i_base_addr, input, AW bits: ROM address of the first beat; captured on accepted start.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port o_done, output, 1 bit: one-cycle pulse after the last beat is accepted.
REQ-012 The block SHALL have port o_rom_en, output, 1 bit: ROM read strobe.
REQ-013 The block SHALL have port o_rom_addr, output, AW bits: ROM read address.
REQ-014 The block SHALL have port i_rom_data, input, DW*in_ch bits: ROM word, valid exactly 1 cycle after o_rom_en.
REQ-015 The block SHALL have port o_EN_w, output, 1 bit: weight-load enable pulse to the FC layer.
REQ-016 The block SHALL have port o_data, output, DW*in_ch bits: beat payload; lane k is bits [k*DW +: DW].
REQ-017 The block SHALL have port o_stb_out, output, 1 bit: beat valid.
REQ-018 The block SHALL have port i_ack_in, input, 1 bit: FC layer accept; a transfer occurs on a cycle with o_stb_out and i_ack_in both high.

Function
REQ-019 BIAS_BEATS SHALL equal ceil(out_ch/in_ch) with minimum 1; WGT_BEATS SHALL equal in_seq*out_ch; TOTAL SHALL equal BIAS_BEATS+WGT_BEATS.
REQ-020 The FSM SHALL have states IDLE, START, FETCH, CAPT, SEND, DONE.
REQ-021 IDLE->START SHALL occur on i_start; the block SHALL capture i_base_addr and clear the beat counter.
REQ-022 In START, o_EN_w SHALL be high for exactly that one cycle, after which the FSM SHALL go to FETCH.
REQ-023 In FETCH, o_rom_en SHALL be high for one cycle with o_rom_addr = base + beat counter (modulo 2^AW), after which the FSM SHALL go to CAPT.
REQ-024 In CAPT, i_rom_data SHALL be registered into o_data and o_stb_out SHALL be set for the next cycle, after which the FSM SHALL go to SEND.
REQ-025 In SEND, o_stb_out and o_data SHALL hold stable until the transfer occurs.
REQ-026 On a transfer in SEND, o_stb_out SHALL drop next cycle; if the beat counter equals TOTAL-1 the FSM SHALL go to DONE, else the counter SHALL increment and the FSM SHALL go to FETCH.
REQ-027 In DONE, o_done SHALL be high for one cycle, after which the FSM SHALL return to IDLE.
REQ-028 Beat order SHALL be BIAS_BEATS bias words first, then WGT_BEATS weight words, in ROM address order; the ROM image alone defines their content.
REQ-029 The minimum beat period SHALL be 3 cycles (FETCH, CAPT, SEND with immediate ack).
REQ-030 i_ack_in SHALL be ignored outside SEND; i_start SHALL be ignored outside IDLE.
REQ-031 o_stb_out SHALL never be high in the same cycle as o_EN_w.

Reset
REQ-032 On RST, state SHALL be IDLE and o_busy, o_done, o_rom_en, o_EN_w, o_stb_out, o_rom_addr, o_data and the beat counter SHALL all be 0, taking effect immediately (asynchronous).
REQ-033 RST asserted mid-load SHALL abort the load with no further beats; after release the block SHALL wait for a new i_start.

Structure
REQ-034 No shared package SHALL be used; state encodings SHALL be localparams and BIAS_BEATS/WGT_BEATS/TOTAL SHALL be derived localparams.
REQ-035 The block SHALL be a single module with no sub-modules; the ROM is external.

Verification
REQ-036 Defaults, base=0x10, ack held high: o_EN_w 1 pulse; 6 transfers from addresses 0x10..0x15 in order; o_done 1 cycle after the 6th; beat period 3 cycles.
REQ-037 Ack withheld 4 cycles on beat 2: o_stb_out and o_data stay stable and o_rom_en stays low until ack; exactly 6 transfers in total.
REQ-038 i_start pulsed during beat 3: ignored, no restart, address sequence unchanged.
REQ-039 RST asserted in SEND of beat 4: all outputs 0 the same cycle; after release no stb until a new i_start, and the next run starts at its own base.
REQ-040 out_ch=20, in_ch=16, in_seq=2: 2 bias + 40 weight beats = 42 transfers; base=0xF0 with AW=8 wraps the address through 0xFF->0x00.
REQ-041 Scoreboard: connect to the FC layer model and check that the loaded biases and weights equal the ROM image.
